// File: rtl/sm_imem_pkg.sv
// Shared types and helpers for the instruction-ROM arbiter (sm_imem_arb).
// Holds the port indices, the response record and the address legality check.
package sm_imem_pkg;

    localparam int PORT_F = 0;
    localparam int PORT_D = 1;

    // One bit wider than the bus, so ROM_SIZE*4 cannot overflow for any ROM size.
    localparam int ADDR_W = 33;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    // Misaligned, or beyond the last ROM byte. The full 32-bit address is compared,
    // so high addresses never alias back into the ROM.
    function automatic logic addr_err(input logic [31:0] addr, input int rom_size);
        logic [ADDR_W-1:0] limit;
        limit = ADDR_W'(rom_size) << 2;
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/sm_imem_starve.sv
// Grant decision for the two ROM requesters. D normally wins a conflict, but after
// MAX_WAIT consecutive denied cycles F is force-granted so fetch always progresses.
module sm_imem_starve #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic f_req,
    input  logic d_req,
    output logic f_gnt,
    output logic d_gnt
);

    logic [3:0] starve_cnt;
    logic       force_f;

    assign force_f = (starve_cnt == 4'(MAX_WAIT));
    assign f_gnt   = rst_n & f_req & (~d_req | force_f);
    assign d_gnt   = rst_n & d_req & ~(f_req & force_f);

    // Counts consecutive cycles in which F asked and was refused; saturates at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (f_req && !f_gnt) begin
            if (!force_f) starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/sm_imem_arb.sv
// Shares the single-port instruction ROM between fetch (F) and data (D) with a one-cycle
// registered response. Optional statistics counters: define SM_IMEM_ARB_STATS_EN.
module sm_imem_arb
    import sm_imem_pkg::*;
#(
    parameter int ROM_SIZE = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_rd
`ifdef SM_IMEM_ARB_STATS_EN
    ,
    output logic [31:0] f_cnt,
    output logic [31:0] d_cnt,
    output logic [31:0] conflict_cnt
`endif
);

    resp_t f_resp;
    resp_t d_resp;
    logic  sel_err;

    sm_imem_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .f_req (f_req),
        .d_req (d_req),
        .f_gnt (f_gnt),
        .d_gnt (d_gnt)
    );

    // With no grant the address defaults to F, keeping the ROM input steady.
    assign rom_a   = d_gnt ? d_addr : f_addr;
    assign sel_err = addr_err(rom_a, ROM_SIZE);

    // Only the granted port loads; the idle port keeps its data and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_resp <= '0;
            d_resp <= '0;
        end else begin
            f_resp.valid <= f_gnt;
            d_resp.valid <= d_gnt;
            if (f_gnt) begin
                f_resp.err  <= sel_err;
                f_resp.data <= sel_err ? 32'h0 : rom_rd;
            end
            if (d_gnt) begin
                d_resp.err  <= sel_err;
                d_resp.data <= sel_err ? 32'h0 : rom_rd;
            end
        end
    end

    assign f_rvalid = f_resp.valid;
    assign f_err    = f_resp.err;
    assign f_rdata  = f_resp.data;
    assign d_rvalid = d_resp.valid;
    assign d_err    = d_resp.err;
    assign d_rdata  = d_resp.data;

`ifdef SM_IMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt        <= '0;
            d_cnt        <= '0;
            conflict_cnt <= '0;
        end else begin
            if (f_gnt)          f_cnt        <= f_cnt + 32'd1;
            if (d_gnt)          d_cnt        <= d_cnt + 32'd1;
            if (f_req && d_req) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sm_imem_arb.sv
// Directed bench for sm_imem_arb: a per-cycle reference model on the falling edge plus
// literal checks for the key scenarios. Define SM_IMEM_ARB_STATS_EN to cover the counters.
module tb_sm_imem_arb;

    localparam int ROM_SIZE = 64;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] rom_a;
    logic [31:0] rom_rd;
`ifdef SM_IMEM_ARB_STATS_EN
    logic [31:0] f_cnt;
    logic [31:0] d_cnt;
    logic [31:0] conflict_cnt;
`endif

    logic [31:0] rom_mem [ROM_SIZE];
    int          n_vec = 0;
    int          n_err = 0;

    sm_imem_arb #(.ROM_SIZE(ROM_SIZE), .MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .rom_a    (rom_a),
        .rom_rd   (rom_rd)
`ifdef SM_IMEM_ARB_STATS_EN
        ,
        .f_cnt        (f_cnt),
        .d_cnt        (d_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Combinational ROM: word index is the byte address divided by four.
    assign rom_rd = rom_mem[rom_a[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected response for an address, straight from the legality rules.
    function automatic logic [32:0] lookup(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a);
        if ((a % 4) != 0 || ua >= ROM_SIZE * 4) return {1'b1, 32'h0};
        return {1'b0, rom_mem[a / 4]};
    endfunction

    // Reference model: denied-streak count, pending responses, last data per port.
    int          streak = 0;
    logic        pend_f = 0, pend_d = 0;
    logic        exp_fe = 0, exp_de = 0;
    logic [31:0] exp_fd = 0, exp_dd = 0;
    logic        eg_f, eg_d;
    logic [32:0] r;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rst_f_rdata", f_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            chk("rst_f_err", 32'(f_err), 32'd0);
            chk("rst_d_err", 32'(d_err), 32'd0);
            chk("rst_f_gnt", 32'(f_gnt), 32'd0);
            chk("rst_d_gnt", 32'(d_gnt), 32'd0);
            streak = 0; pend_f = 0; pend_d = 0;
            exp_fe = 0; exp_de = 0; exp_fd = 0; exp_dd = 0;
        end else begin
            chk("m_f_rvalid", 32'(f_rvalid), 32'(pend_f));
            chk("m_d_rvalid", 32'(d_rvalid), 32'(pend_d));
            chk("m_f_rdata", f_rdata, exp_fd);
            chk("m_d_rdata", d_rdata, exp_dd);
            if (pend_f) chk("m_f_err", 32'(f_err), 32'(exp_fe));
            if (pend_d) chk("m_d_err", 32'(d_err), 32'(exp_de));
            if (f_req && d_req) begin
                eg_f = (streak == MAX_WAIT);
                eg_d = !eg_f;
            end else begin
                eg_f = f_req;
                eg_d = d_req;
            end
            chk("m_f_gnt", 32'(f_gnt), 32'(eg_f));
            chk("m_d_gnt", 32'(d_gnt), 32'(eg_d));
            chk("m_rom_a", rom_a, eg_d ? d_addr : f_addr);
            pend_f = eg_f;
            pend_d = eg_d;
            if (eg_f) begin r = lookup(f_addr); exp_fe = r[32]; exp_fd = r[31:0]; end
            if (eg_d) begin r = lookup(d_addr); exp_de = r[32]; exp_dd = r[31:0]; end
            streak = (f_req && !eg_f) ? ((streak < MAX_WAIT) ? streak + 1 : MAX_WAIT) : 0;
        end
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    endtask

    string       exp_pat = "DDDDFDDDDF";
    string       got_pat;
    logic [31:0] bnd_addr [6] = '{32'hFC, 32'h100, 32'hFFFF_FFFC, 32'h3, 32'h4, 32'h0};

    initial begin
        for (int i = 0; i < ROM_SIZE; i++) rom_mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
        rom_mem[2] = 32'h0050_0093;
        rst_n = 1'b0; f_req = 0; f_addr = 0; d_req = 0; d_addr = 0;
        @(negedge clk);
        chk("reset_f_rvalid", 32'(f_rvalid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Grant, then reset lands before the response edge: response is dropped.
        drive(1, 32'h8, 0, 0);
        @(negedge clk);
        chk("midrst_gnt", 32'(f_gnt), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", 32'(f_rvalid), 32'd0);
        chk("midrst_gnt_low", 32'(f_gnt), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; f_req = 0;

        // Both requesting for ten cycles: D x4 then forced F, twice.
        got_pat = "";
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h10, 1, 32'h14);
            @(negedge clk);
            got_pat = {got_pat, f_gnt ? "F" : (d_gnt ? "D" : "-")};
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 10; k++)
            chk($sformatf("pattern_%0d", k), 32'(got_pat[k]), 32'(exp_pat[k]));
`ifdef SM_IMEM_ARB_STATS_EN
        chk("stats_d_cnt", d_cnt, 32'd8);
        chk("stats_f_cnt", f_cnt, 32'd2);
        chk("stats_conflict", conflict_cnt, 32'd10);
`endif

        // Fetch alone from 0x8.
        drive(1, 32'h8, 0, 0);
        @(negedge clk);
        chk("f8_gnt", 32'(f_gnt), 32'd1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("f8_rvalid", 32'(f_rvalid), 32'd1);
        chk("f8_rdata", f_rdata, 32'h0050_0093);
        chk("f8_err", 32'(f_err), 32'd0);

        // Data port errors: out of range, then misaligned.
        drive(0, 0, 1, 32'h100);
        drive(0, 0, 1, 32'h6);
        @(negedge clk);
        chk("d100_rvalid", 32'(d_rvalid), 32'd1);
        chk("d100_err", 32'(d_err), 32'd1);
        chk("d100_rdata", d_rdata, 32'd0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("d6_err", 32'(d_err), 32'd1);
        chk("d6_rdata", d_rdata, 32'd0);

        // Alternating single-cycle F/D requests; idle port data must hold.
        drive(1, 32'h0, 0, 0);
        drive(0, 0, 1, 32'h4);
        @(negedge clk);
        chk("alt_f_rdata", f_rdata, 32'h1000_0000);
        drive(1, 32'h0, 0, 0);
        @(negedge clk);
        chk("alt_d_rdata", d_rdata, 32'h1001_0003);
        chk("alt_f_hold", f_rdata, 32'h1000_0000);
        drive(0, 0, 1, 32'h4);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Back-to-back fetches across the range boundary and high addresses.
        for (int i = 0; i < 6; i++) drive(1, bnd_addr[i], 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("dhigh_err", 32'(d_err), 32'd1);
        chk("dhigh_rdata", d_rdata, 32'd0);
        drive(0, 0, 1, 32'hFC);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("dfc_rdata", d_rdata, 32'h1000_0000 + 63 * 32'h0001_0003);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
